instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 149 ++++++++++++++
 tb/tb_instr_encoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: encodes one R/I/S/B request per cycle into a 32-bit
// instruction word. The word is held in a single output register with
// valid/ready handshaking, and each word carries a byte address that
// advances by 4 for every word delivered downstream.
//
// Build option: define ENC_CHECK_EN to enable immediate range/alignment
// checks. With checks on, bad requests are dropped and counted in
// err_flag/err_cnt. Without the macro, every request is emitted and the
// error outputs stay 0.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              clr_err,
    output logic              err_flag,
    output logic [7:0]        err_cnt
);

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_S = 2'b10;
    localparam logic [1:0] FMT_B = 2'b11;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    // Pack fields into the 32-bit word. Fields a format does not use are dropped.
    function automatic logic [31:0] encode(
        input logic [1:0]  fmt,
        input logic [6:0]  opcode,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [12:0] imm
    );
        logic [31:0] word;
        case (fmt)
            FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            default: word = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], opcode};
        endcase
        return word;
    endfunction

    logic              vld_p1;
    logic [31:0]       instr_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic              accept;
    logic              bad_req;

    // The output register can take a new word whenever it is empty or draining.
    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef ENC_CHECK_EN
    // I/S immediates must fit in 12 signed bits; B offsets must be even.
    function automatic logic imm_bad(input logic [1:0] fmt, input logic [12:0] imm);
        logic bad;
        case (fmt)
            FMT_I, FMT_S: bad = (imm[12] != imm[11]);
            FMT_B:        bad = imm[0];
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Count up by one, holding at the maximum value.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    logic       err_flag_q;
    logic [7:0] err_cnt_q;

    assign bad_req = accept && imm_bad(in_fmt, in_imm);

    // Sticky error state. A new error in the same cycle as a clear restarts the count at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else if (bad_req) begin
            err_flag_q <= 1'b1;
            err_cnt_q  <= clr_err ? 8'd1 : sat_inc(err_cnt_q);
        end else if (clr_err) begin
            err_flag_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end
    end

    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;
`else
    logic unused_clr_err;

    assign bad_req        = 1'b0;
    assign err_flag       = 1'b0;
    assign err_cnt        = 8'd0;
    assign unused_clr_err = clr_err;
`endif

    // Output register: load on a good accept, empty after a handshake, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            instr_p1 <= 32'd0;
        end else if (accept && !bad_req) begin
            vld_p1   <= 1'b1;
            instr_p1 <= encode(in_fmt, in_opcode, in_funct3, in_funct7,
                               in_rd, in_rs1, in_rs2, in_imm);
        end else if (out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    // Word address: points at the current (or next) word and steps after each delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p1 <= BASE;
        end else if (vld_p1 && out_ready) begin
            addr_p1 <= addr_p1 + STEP;
        end
    end

    assign out_valid = vld_p1;
    assign out_instr = instr_p1;
    assign out_addr  = addr_p1;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: reset state, encoding of each format,
// back-pressure, error handling (with or without ENC_CHECK_EN), address
// wrap and reset during a pending word.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_fmt = 2'b00;
    logic [6:0]  in_opcode = 7'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [6:0]  in_funct7 = 7'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [12:0] in_imm = 13'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        clr_err = 1'b0;
    logic        err_flag;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_addr;

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .clr_err   (clr_err),
        .err_flag  (err_flag),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [12:0] imm);
        in_fmt    = f;
        in_opcode = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    task automatic word(input string tag, input logic [31:0] exp_instr, input logic [7:0] addr);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_instr"}, out_instr, exp_instr);
        chk({tag, "_addr"}, {24'd0, out_addr}, {24'd0, addr});
    endtask

    initial begin
        // reset held, clock running
        repeat (2) @(negedge clk);
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr", {24'd0, out_addr}, 32'd0);
        chk("rst_flag", {31'd0, err_flag}, 32'd0);
        chk("rst_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        #1 chk("rel_ready", {31'd0, in_ready}, 32'd1);
        exp_addr = 8'h00;

        // ADDI x1,x0,7
        @(negedge clk);
        req(2'b01, 7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 13'd7);
        @(negedge clk);
        in_valid = 1'b0;
        word("addi7", 32'h00700093, exp_addr);
        exp_addr += 8'd4;
        @(negedge clk);
        chk("idle_vld", {31'd0, out_valid}, 32'd0);
        chk("idle_addr", {24'd0, out_addr}, {24'd0, exp_addr});

        // SW, BNE +8, BNE -4 back to back
        req(2'b10, 7'h23, 3'b010, 7'h00, 5'd0, 5'd0, 5'd1, 13'd4);
        @(negedge clk);
        req(2'b11, 7'h63, 3'b001, 7'h00, 5'd0, 5'd3, 5'd4, 13'd8);
        word("sw", 32'h00102223, exp_addr);
        exp_addr += 8'd4;
        @(negedge clk);
        req(2'b11, 7'h63, 3'b001, 7'h00, 5'd0, 5'd3, 5'd4, 13'h1FFC);
        word("bne8", 32'h00419463, exp_addr);
        exp_addr += 8'd4;
        @(negedge clk);
        in_valid = 1'b0;
        word("bnem4", 32'hFE419EE3, exp_addr);
        exp_addr += 8'd4;

        // ADD x3,x1,x2 under back-pressure
        @(negedge clk);
        req(2'b00, 7'h33, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 13'h1ABC);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            word("add_hold", 32'h002081B3, exp_addr);
            chk("add_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("add_rel_ready", {31'd0, in_ready}, 32'd1);
        exp_addr += 8'd4;
        @(negedge clk);
        chk("add_done_vld", {31'd0, out_valid}, 32'd0);
        chk("add_done_addr", {24'd0, out_addr}, {24'd0, exp_addr});

        // out-of-range I and misaligned B, then ADDI x5,x5,-1
        req(2'b01, 7'h13, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 13'h0800);
        @(negedge clk);
        req(2'b11, 7'h63, 3'b001, 7'h00, 5'd0, 5'd3, 5'd4, 13'd5);
`ifdef ENC_CHECK_EN
        @(negedge clk);
        in_valid = 1'b0;
        chk("err_vld", {31'd0, out_valid}, 32'd0);
        chk("err_flag", {31'd0, err_flag}, 32'd1);
        chk("err_cnt", {24'd0, err_cnt}, 32'd2);
        chk("err_addr", {24'd0, out_addr}, {24'd0, exp_addr});
        req(2'b01, 7'h13, 3'b000, 7'h00, 5'd5, 5'd5, 5'd0, 13'h1FFF);
        @(negedge clk);
        req(2'b11, 7'h63, 3'b001, 7'h00, 5'd0, 5'd3, 5'd4, 13'd5);
        clr_err = 1'b1;
        word("addim1", 32'hFFF28293, exp_addr);
        exp_addr += 8'd4;
        @(negedge clk);
        in_valid = 1'b0;
        chk("clr_err_flag", {31'd0, err_flag}, 32'd1);
        chk("clr_err_cnt", {24'd0, err_cnt}, 32'd1);
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_flag", {31'd0, err_flag}, 32'd0);
        chk("clr_cnt", {24'd0, err_cnt}, 32'd0);
`else
        word("i2048", 32'h80000013, exp_addr);
        exp_addr += 8'd4;
        @(negedge clk);
        req(2'b01, 7'h13, 3'b000, 7'h00, 5'd5, 5'd5, 5'd0, 13'h1FFF);
        clr_err = 1'b1;
        word("b5", 32'h00419263, exp_addr);
        exp_addr += 8'd4;
        @(negedge clk);
        in_valid = 1'b0;
        clr_err = 1'b0;
        word("addim1", 32'hFFF28293, exp_addr);
        chk("nochk_flag", {31'd0, err_flag}, 32'd0);
        chk("nochk_cnt", {24'd0, err_cnt}, 32'd0);
        exp_addr += 8'd4;
        @(negedge clk);
`endif

        // reset while a word is stalled
        req(2'b00, 7'h33, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 13'd0);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        word("pre_rst", 32'h002081B3, exp_addr);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", {31'd0, out_valid}, 32'd0);
        chk("arst_instr", out_instr, 32'd0);
        chk("arst_addr", {24'd0, out_addr}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("arel_ready", {31'd0, in_ready}, 32'd1);

        // 65 words streamed back to back: the 65th wraps to address 0
        for (int k = 0; k <= 64; k++) begin
            @(negedge clk);
            if (k > 0) word("stream", (32'(k - 1) << 20) | 32'h93, 8'((k - 1) * 4));
            req(2'b01, 7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 13'(k));
        end
        @(negedge clk);
        in_valid = 1'b0;
        word("wrap", 32'h04000093, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
